// File: rtl/load_pkg.sv
// Shared definitions for the load path: funct3 encodings, FSM states and
// the access-size decode used by both the control FSM and the extender.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_DONE
    } state_t;

    // Encoding 7 has no size; legality against XLEN is judged by the extender.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return 4'd1;
            F3_LH, F3_LHU: return 4'd2;
            F3_LW, F3_LWU: return 4'd4;
            F3_LD:         return 4'd8;
            default:       return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend_xlen.sv
// Combinational field extraction and sign/zero extension of already-shifted
// load data; also flags funct3 encodings that are illegal for this XLEN.
module load_extend_xlen
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] shifted_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o,
    output logic            illegal_o
);

    always_comb begin
        data_o    = '0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = XLEN'($signed(shifted_i[7:0]));
            F3_LH:  data_o = XLEN'($signed(shifted_i[15:0]));
            F3_LW:  data_o = XLEN'($signed(shifted_i[31:0]));
            F3_LBU: data_o = XLEN'(shifted_i[7:0]);
            F3_LHU: data_o = XLEN'(shifted_i[15:0]);
            F3_LD: begin
                if (XLEN == 64) data_o = shifted_i;
                else            illegal_o = 1'b1;
            end
            F3_LWU: begin
                if (XLEN == 64) data_o = XLEN'(shifted_i[31:0]);
                else            illegal_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load path between MEM stage and data bus: issues one or two word reads,
// merges boundary-crossing loads and returns the extended result.
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [2:0]        req_funct3_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   resp_data_o,
    output logic              resp_fault_o
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              cross_q, cross_d;
    logic [XLEN-1:0]   word0_q, word0_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              resp_fault_q, resp_fault_d;

    logic [OFF_W-1:0]  req_off;
    logic              req_cross;
    logic [2*XLEN-1:0] merge_buf;
    logic [XLEN-1:0]   shifted;
    logic [2:0]        ext_f3;
    logic [XLEN-1:0]   ext_data;
    logic              ext_illegal;

    assign req_off   = req_addr_i[OFF_W-1:0];
    assign req_cross = (int'(req_off) + int'(size_bytes(req_funct3_i))) > BYTES;

    // The second beat is merged straight off the bus, so only word0 is stored.
    assign merge_buf = (state_q == S_WAIT1) ? {mem_rdata_i, word0_q}
                                            : {{XLEN{1'b0}}, mem_rdata_i};
    assign shifted   = XLEN'(merge_buf >> {off_q, 3'b000});

    // In IDLE the extender only serves as the legality check on the request.
    assign ext_f3 = (state_q == S_IDLE) ? req_funct3_i : f3_q;

    load_extend_xlen #(.XLEN(XLEN)) u_ext (
        .shifted_i (shifted),
        .funct3_i  (ext_f3),
        .data_o    (ext_data),
        .illegal_o (ext_illegal)
    );

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        off_d        = off_q;
        f3_d         = f3_q;
        cross_d      = cross_q;
        word0_d      = word0_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    off_d      = req_off;
                    f3_d       = req_funct3_i;
                    cross_d    = req_cross;
                    mem_addr_d = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (ext_illegal || (req_cross && !MISALIGN_EN)) begin
                        resp_data_d  = '0;
                        resp_fault_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        state_d = S_ISSUE0;
                    end
                end
            end
            S_ISSUE0: if (mem_req_ready_i) state_d = S_WAIT0;
            S_WAIT0: begin
                if (mem_rvalid_i) begin
                    word0_d = mem_rdata_i;
                    if (cross_q) begin
                        mem_addr_d = mem_addr_q + ADDR_W'(BYTES);
                        state_d    = S_ISSUE1;
                    end else begin
                        resp_data_d  = ext_data;
                        resp_fault_d = 1'b0;
                        state_d      = S_DONE;
                    end
                end
            end
            S_ISSUE1: if (mem_req_ready_i) state_d = S_WAIT1;
            S_WAIT1: begin
                if (mem_rvalid_i) begin
                    resp_data_d  = ext_data;
                    resp_fault_d = 1'b0;
                    state_d      = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= '0;
            off_q        <= '0;
            f3_q         <= '0;
            cross_q      <= 1'b0;
            word0_q      <= '0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            cross_q      <= cross_d;
            word0_q      <= word0_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign mem_req_valid_o = (state_q == S_ISSUE0) || (state_q == S_ISSUE1);
    assign mem_addr_o      = mem_addr_q;
    assign resp_valid_o    = (state_q == S_DONE);
    assign resp_data_o     = resp_data_q;
    assign resp_fault_o    = resp_fault_q;

endmodule
